dst_reg_pipe: RTL and testbench
===============================

# dst_reg_pipe

- Parametrised successor to the two-way register-destination mux.
- Selects the write-destination register (rt, rd or link register) per instruction and carries it, with its write-enable, through a configurable number of pipeline stages (default EX/MEM/WB).
- Provides youngest-first forwarding match vectors for two source operands.
- Sits between decode and the register file write port; feeds the forwarding unit.

## Interface
Parameters:
- AW, 5, register address width
- DEPTH, 3, number of pipeline stages carried (≥1); stage 0 = youngest, stage DEPTH-1 drives write-back
- LINK_REG, 31, register index selected for link (JAL-type) writes

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rt  input  AW  rt field of decoded instruction
- rd  input  AW  rd field of decoded instruction
- reg_dst  input  2  00 = rt, 01 = rd, 10 = LINK_REG, 11 = rt (reserved)
- reg_write_in  input  1  decoded instruction writes a register
- stall  input  1  freeze all stages
- flush  input  1  replace incoming entry with a bubble
- src_a  input  AW  source operand A register index
- src_b  input  AW  source operand B register index
- wb_dst  output  AW  destination register at stage DEPTH-1
- wb_we  output  1  register-file write enable at stage DEPTH-1
- fwd_a_sel  output  DEPTH  one-hot: youngest stage matching src_a, else 0
- fwd_b_sel  output  DEPTH  one-hot: youngest stage matching src_b, else 0

## Operation
- Each stage holds {dst[AW], we}. Stage 0 loads sel(rt, rd, LINK_REG by reg_dst) and reg_write_in. Stage k loads stage k-1.
- Register 0 suppression: an entry whose selected dst == 0 is loaded with we = 0; dst is still stored.
- stall = 1: every stage holds its value.
- flush = 1, stall = 0: stage 0 loads {dst = 0, we = 0}; the other stages advance normally.
- flush = 1, stall = 1: stage 0 is cleared to {0, 0}; the other stages hold. Flush wins over stall for stage 0 only.
- wb_dst / wb_we are stage DEPTH-1 contents, driven straight from flops.
- Forwarding match for stage k: we[k] && dst[k] == src && src != 0.
- fwd_x_sel picks the lowest-index (youngest) matching stage; at most one bit is set.
- Forwarding outputs are combinational from the stage flops and src inputs, and are unaffected by stall or flush in the same cycle.

## Timing
- Reset (async assert, sync-released by the system): all stage flops go to {0, 0}.
- After reset: wb_dst = 0, wb_we = 0, fwd_a_sel = 0, fwd_b_sel = 0.
- Latency: an entry presented at edge n appears on wb_dst/wb_we after edge n+DEPTH-1 when unstalled, i.e. in stage 0 after edge n and at the output DEPTH-1 edges later.
- Each stalled cycle adds one cycle of latency to every in-flight entry.
- Reset asserted mid-stream discards all in-flight entries immediately; there is no write-back of discarded entries.
- DEPTH = 1: stage 0 is the write-back stage; forwarding vectors are 1 bit wide.
- Unused reg_dst code 11 behaves exactly as 00.

## Configuration
- DST_PIPE_FWD_EN defined: fwd_a_sel / fwd_b_sel compare logic is built as described above.
- DST_PIPE_FWD_EN undefined: fwd_a_sel and fwd_b_sel are tied to 0. The ports remain, and the pipeline and write-back behaviour are unchanged.

## Test plan
- Reset check: rst_n low mid-stream with 3 valid entries in flight -> wb_we = 0 and wb_dst = 0 immediately; fwd vectors = 0.
- Select + latency (DEPTH = 3): rt = 8, rd = 9, reg_dst = 01, reg_write_in = 1 at edge 0 -> wb_dst = 9, wb_we = 1 after edge 2. Then reg_dst = 10 -> wb_dst = 31. Then reg_dst = 11 with rt = 8 -> wb_dst = 8.
- Zero suppression: rd = 0, reg_dst = 01, reg_write_in = 1 -> wb_we = 0 at write-back; src_a = 0 -> fwd_a_sel = 0.
- Stall/flush: stall for 2 cycles with entries 5, 6, 7 in flight -> wb_dst holds 7 and wb_we stays asserted. flush + stall together -> stage 0 cleared, stages 1–2 unchanged; after release the bubble reaches write-back with wb_we = 0.
- Forwarding priority: stages hold dst 4, 4, 4, all we = 1, src_a = 4 -> fwd_a_sel = 3'b001. Clear stage 0 via flush -> 3'b010. src_b = 12 with no match -> fwd_b_sel = 0.
- Macro off: build without DST_PIPE_FWD_EN and rerun the forwarding scenario -> both vectors stay 0; write-back sequence is identical to the macro-on build.

Source files
------------

// File: rtl/dst_reg_pipe.sv
// rtl/dst_reg_pipe.sv - write-destination select and pipeline carrier with forwarding match (optional DST_PIPE_FWD_EN)
module dst_reg_pipe #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rt,
    input  logic [AW-1:0]    rd,
    input  logic [1:0]       reg_dst,
    input  logic             reg_write_in,
    input  logic             stall,
    input  logic             flush,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    output logic [AW-1:0]    wb_dst,
    output logic             wb_we,
    output logic [DEPTH-1:0] fwd_a_sel,
    output logic [DEPTH-1:0] fwd_b_sel
);

    logic [AW-1:0]    sel_dst;
    logic             sel_we;
    logic [AW-1:0]    dst_q [DEPTH];
    logic [DEPTH-1:0] we_q;

    // Destination select; code 11 falls back to rt, and writes to register 0 are dropped
    always_comb begin
        sel_dst = rt;
        case (reg_dst)
            2'b01:   sel_dst = rd;
            2'b10:   sel_dst = AW'(LINK_REG);
            default: sel_dst = rt;
        endcase
        sel_we = reg_write_in && (sel_dst != '0);
    end

    // Stage flops: flush clears stage 0 even under stall, stall freezes everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= '0;
            end
            we_q <= '0;
        end else begin
            if (flush) begin
                dst_q[0] <= '0;
                we_q[0]  <= 1'b0;
            end else if (!stall) begin
                dst_q[0] <= sel_dst;
                we_q[0]  <= sel_we;
            end
            if (!stall) begin
                for (int k = 1; k < DEPTH; k++) begin
                    dst_q[k] <= dst_q[k-1];
                    we_q[k]  <= we_q[k-1];
                end
            end
        end
    end

    assign wb_dst = dst_q[DEPTH-1];
    assign wb_we  = we_q[DEPTH-1];

`ifdef DST_PIPE_FWD_EN
    // Youngest-first match: scan oldest to youngest so the lowest matching index wins
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (we_q[k] && (dst_q[k] == src_a) && (src_a != '0)) begin
                fwd_a_sel = DEPTH'(1) << k;
            end
            if (we_q[k] && (dst_q[k] == src_b) && (src_b != '0)) begin
                fwd_b_sel = DEPTH'(1) << k;
            end
        end
    end
`else
    logic unused_src;
    assign unused_src = ^{src_a, src_b};
    assign fwd_a_sel  = '0;
    assign fwd_b_sel  = '0;
`endif

endmodule

// File: tb/tb_dst_reg_pipe.sv
// tb/tb_dst_reg_pipe.sv - directed self-checking bench for dst_reg_pipe (DEPTH = 3)
module tb_dst_reg_pipe;

    localparam int AW    = 5;
    localparam int DEPTH = 3;
`ifdef DST_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    rt;
    logic [AW-1:0]    rd;
    logic [1:0]       reg_dst;
    logic             reg_write_in;
    logic             stall;
    logic             flush;
    logic [AW-1:0]    src_a;
    logic [AW-1:0]    src_b;
    logic [AW-1:0]    wb_dst;
    logic             wb_we;
    logic [DEPTH-1:0] fwd_a_sel;
    logic [DEPTH-1:0] fwd_b_sel;

    int n_checks;
    int n_pass;

    dst_reg_pipe #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(31)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rt           (rt),
        .rd           (rd),
        .reg_dst      (reg_dst),
        .reg_write_in (reg_write_in),
        .stall        (stall),
        .flush        (flush),
        .src_a        (src_a),
        .src_b        (src_b),
        .wb_dst       (wb_dst),
        .wb_we        (wb_we),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected forwarding vector depends on whether the compare logic is built
    function automatic logic [31:0] fx(input logic [31:0] v);
        return FWD ? v : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] r);
        rt           = r;
        reg_dst      = 2'b00;
        reg_write_in = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; rt = '0; rd = '0; reg_dst = 2'b00; reg_write_in = 1'b0;
        stall = 1'b0; flush = 1'b0; src_a = '0; src_b = '0;
        step();
        check("reset_wb_dst", wb_dst, 0);
        check("reset_wb_we", wb_we, 0);
        check("reset_fwd_a", fwd_a_sel, 0);
        check("reset_fwd_b", fwd_b_sel, 0);
        rst_n = 1'b1;
        step();

        // Select and latency: rd, link, reserved code
        rt = 5'd8; rd = 5'd9; reg_dst = 2'b01; reg_write_in = 1'b1;
        step();
        reg_dst = 2'b10;
        step();
        reg_dst = 2'b11;
        step();
        check("sel_rd_dst", wb_dst, 9);
        check("sel_rd_we", wb_we, 1);
        src_a = 5'd31; src_b = 5'd9;
        #1;
        check("fwd_a_link_stage1", fwd_a_sel, fx(3'b010));
        check("fwd_b_rd_stage2", fwd_b_sel, fx(3'b100));
        reg_write_in = 1'b0;
        step();
        check("sel_link_dst", wb_dst, 31);
        check("sel_link_we", wb_we, 1);
        step();
        check("sel_code11_dst", wb_dst, 8);
        check("sel_code11_we", wb_we, 1);

        // Register 0 suppression
        rd = 5'd0; reg_dst = 2'b01; reg_write_in = 1'b1; src_a = 5'd0;
        step();
        #1;
        check("zero_fwd_a", fwd_a_sel, 0);
        reg_write_in = 1'b0;
        step();
        step();
        check("zero_wb_we", wb_we, 0);
        check("zero_wb_dst", wb_dst, 0);

        // Stall / flush: entries 7, 6, 5 -> stage2 = 7, stage1 = 6, stage0 = 5
        push(5'd7);
        push(5'd6);
        push(5'd5);
        check("pre_stall_wb_dst", wb_dst, 7);
        stall = 1'b1; rt = 5'd10;
        step();
        check("stall1_wb_dst", wb_dst, 7);
        check("stall1_wb_we", wb_we, 1);
        step();
        check("stall2_wb_dst", wb_dst, 7);
        check("stall2_wb_we", wb_we, 1);
        src_a = 5'd5; src_b = 5'd6;
        #1;
        check("stall_fwd_a_s0", fwd_a_sel, fx(3'b001));
        check("stall_fwd_b_s1", fwd_b_sel, fx(3'b010));
        flush = 1'b1;
        step();
        check("flush_stall_fwd_a", fwd_a_sel, 0);
        check("flush_stall_fwd_b", fwd_b_sel, fx(3'b010));
        check("flush_stall_wb_dst", wb_dst, 7);
        stall = 1'b0; flush = 1'b0; reg_write_in = 1'b0;
        step();
        check("release_wb_dst", wb_dst, 6);
        check("release_wb_we", wb_we, 1);
        step();
        check("bubble_wb_dst", wb_dst, 0);
        check("bubble_wb_we", wb_we, 0);

        // Forwarding priority
        push(5'd4);
        push(5'd4);
        push(5'd4);
        src_a = 5'd4; src_b = 5'd12;
        #1;
        check("prio_all_fwd_a", fwd_a_sel, fx(3'b001));
        check("prio_nomatch_fwd_b", fwd_b_sel, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("prio_flushed_fwd_a", fwd_a_sel, fx(3'b010));
        check("prio_wb_dst", wb_dst, 4);

        // Mid-stream reset with three valid entries in flight
        push(5'd3);
        push(5'd2);
        push(5'd1);
        src_a = 5'd1; src_b = 5'd3;
        #1;
        check("pre_rst_fwd_a", fwd_a_sel, fx(3'b001));
        check("pre_rst_wb_we", wb_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wb_dst", wb_dst, 0);
        check("midrst_wb_we", wb_we, 0);
        check("midrst_fwd_a", fwd_a_sel, 0);
        check("midrst_fwd_b", fwd_b_sel, 0);
        reg_write_in = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_wb_we", wb_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
